// File: rtl/alu_gcd_ctrl_if.sv
// alu_gcd_ctrl_if: requester handshake and ALU drive/response bundle for the GCD controller
interface alu_gcd_ctrl_if;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        ready;
  logic        done;
  logic        err;
  logic [15:0] gcd;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_c;
  logic [2:0]  alu_opc;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;
  modport master (
    input  start, a_in, b_in, alu_w, alu_zer, alu_neg,
    output ready, done, err, gcd, alu_a, alu_b, alu_c, alu_opc
  );
  modport slave (
    output start, a_in, b_in, alu_w, alu_zer, alu_neg,
    input  ready, done, err, gcd, alu_a, alu_b, alu_c, alu_opc
  );
endinterface

// File: rtl/alu_gcd_ctrl.sv
// alu_gcd_ctrl: subtractive-Euclid GCD sequencer that does all arithmetic through an external ALU
module alu_gcd_ctrl (
  input  logic           clk,
  input  logic           rst,
  alu_gcd_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, NEG, SUB, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, nb_q, nb_d, gcd_q, gcd_d;
  logic        err_q, err_d;
  logic        bad;
  assign bad = bus.a_in == '0 || bus.a_in[15] || bus.b_in == '0 || bus.b_in[15];
  assign bus.ready = state_q == IDLE;
  assign bus.done  = state_q == DONE;
  assign bus.err   = err_q;
  assign bus.gcd   = gcd_q;
  assign bus.alu_c = 1'b0;
  // state and datapath registers, reset is synchronous active-low
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      nb_q    <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      nb_q    <= nb_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end
  // next state and ALU drive; NB is computed once per B and reused across SUB runs
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    nb_d        = nb_q;
    gcd_d       = gcd_q;
    err_d       = err_q;
    bus.alu_opc = 3'b111;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.a_in;
        b_d     = bus.b_in;
        err_d   = bad;
        gcd_d   = bad ? '0 : gcd_q;
        state_d = bad ? DONE : NEG;
      end
      NEG: begin
        bus.alu_opc = 3'b000;
        bus.alu_a   = b_q;
        nb_d        = bus.alu_w;
        state_d     = SUB;
      end
      SUB: begin
        bus.alu_opc = 3'b010;
        bus.alu_a   = a_q;
        bus.alu_b   = nb_q;
        if (bus.alu_zer) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (bus.alu_neg) begin
          a_d     = b_q;
          b_d     = a_q;
          state_d = NEG;
        end else a_d = bus.alu_w;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_gcd_ctrl.sv
// tb_alu_gcd_ctrl: scoreboard bench with a behavioural ALU and a GCD/latency reference model
module tb_alu_gcd_ctrl;
  typedef struct {
    logic [15:0] g;
    logic        e;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  alu_gcd_ctrl_if bus ();
  alu_gcd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.alu_w   = bus.alu_opc == 3'b000 ? -bus.alu_a :
                       bus.alu_opc == 3'b010 ? bus.alu_a + bus.alu_b + {15'd0, bus.alu_c} : 16'd0;
  assign bus.alu_zer = bus.alu_w == 16'd0;
  assign bus.alu_neg = bus.alu_w[15];
  exp_t sb[$];
  exp_t em;
  int   n_vec = 0, n_err = 0, cyc = 0, acc = 0, done_cyc = 0, gap = 0, ndone = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(int a, int b);
    exp_t r;
    int   t, lat;
    if (a <= 0 || b <= 0 || a > 32767 || b > 32767) begin
      r.g = 16'd0; r.e = 1'b1; r.lat = 0;
      return r;
    end
    lat = 1;
    while (a != b) begin
      if (a < b) begin
        t = a; a = b; b = t; lat += 2;
      end else begin
        a -= b; lat++;
      end
    end
    r.g = a[15:0]; r.e = 1'b0; r.lat = lat + 1;
    return r;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst && bus.ready && bus.start) begin
      acc = cyc + 1;
      gap = acc - done_cyc;
    end
    if (bus.done) begin
      ndone++;
      done_cyc = cyc;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        em = sb.pop_front();
        chk("gcd", bus.gcd, em.g);
        chk("err", bus.err, em.e);
        chk("lat", cyc - acc, em.lat);
      end
    end
  end
  task automatic go(logic [15:0] a, logic [15:0] b, bit push = 1'b1);
    @(posedge clk);
    #1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || !bus.ready) && n < 2000);
    if (n >= 2000) chk("timeout", 0, 1);
  endtask
  initial begin
    logic [2:0] seq [6];
    int d0, n;
    seq = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd2, 3'd2};
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_gcd", bus.gcd, 0);
    chk("rst_opc", bus.alu_opc, 3'b111);
    chk("rst_a", bus.alu_a, 0);
    chk("rst_b", bus.alu_b, 0);
    rst = 1'b1;
    go(16'd12, 16'd8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("opc_seq", bus.alu_opc, seq[i]);
      chk("alu_c", bus.alu_c, 0);
    end
    wait_idle();
    go(16'd5, 16'd5);
    wait_idle();
    go(16'd7, 16'd1);
    wait_idle();
    go(16'd0, 16'd9);
    wait_idle();
    chk("err_held", bus.err, 1);
    go(16'h8000, 16'd3);
    wait_idle();
    go(16'd9, 16'd6);
    wait_idle();
    chk("err_clr", bus.err, 0);
    d0 = ndone;
    go(16'd12, 16'd8);
    go(16'd4, 16'd2, 1'b0);
    wait_idle();
    chk("busy_done", ndone - d0, 1);
    chk("busy_gcd", bus.gcd, 4);
    d0 = ndone;
    go(16'd12, 16'd8, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_gcd", bus.gcd, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_opc", bus.alu_opc, 3'b111);
    chk("mid_rst_done", bus.done, 0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    chk("mid_rst_nodone", ndone - d0, 0);
    d0 = ndone;
    @(posedge clk);
    #1;
    bus.a_in  = 16'd20;
    bus.b_in  = 16'd15;
    bus.start = 1'b1;
    sb.push_back(model(20, 15));
    sb.push_back(model(20, 15));
    n = 0;
    while (ndone < d0 + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1 bus.start = 1'b0;
    chk("b2b_cnt", ndone - d0, 2);
    chk("b2b_gap", gap, 2);
    wait_idle();
    repeat (6) begin
      go(16'($urandom_range(1, 200)), 16'($urandom_range(1, 200)));
      wait_idle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_gcd_ctrl.md
# alu_gcd_ctrl

Sequential controller that computes the greatest common divisor of two positive 15-bit signed operands by subtractive Euclid iteration. It contains no arithmetic of its own: every negate and subtract is issued to the team's 16-bit ALU through its opcode/operand/flag interface. It decides the next step from the ALU's `zer`/`neg` flags, acting as the driving end of that interface. It sits between a start/done requester and one ALU instance.

## Interface

Parameters:
- None. Datapath width is fixed at 16 to match the ALU.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Reset, synchronous and active-low; sampled on `clk` rising edge.
- `start`  in  1  Request. Sampled only in IDLE.
- `a_in`  in  16  Operand A (signed); valid range 1..32767.
- `b_in`  in  16  Operand B (signed); valid range 1..32767.
- `ready`  out  1  High in IDLE.
- `done`  out  1  One-cycle pulse when a result (or error) is available.
- `err`  out  1  Set when an accepted operand was ≤ 0; held until the next accepted start.
- `gcd`  out  16  Result; held until the next completion.
- `alu_a`  out  16  To ALU `inA`.
- `alu_b`  out  16  To ALU `inB`.
- `alu_c`  out  1  To ALU `inC`; constant 0.
- `alu_opc`  out  3  To ALU `opc`.
- `alu_w`  in  16  From ALU `outW`. Combinational result of the current-cycle drive.
- `alu_zer`  in  1  From ALU `zer`.
- `alu_neg`  in  1  From ALU `neg`.

## Operation

- Internal registers: A, B, NB (holds −B), 16 bits each.
- The ALU is combinational. The controller drives operands from registers and samples `alu_w`/flags at the end of the same cycle.
- States and transitions:
  - **IDLE**
    - `ready`=1; `alu_opc`=111, `alu_a`=`alu_b`=0.
    - On `start`=1: latch A←`a_in`, B←`b_in`, clear `err`.
    - If either operand is 0 or has bit 15 set: go to DONE with `err`←1 and `gcd`←0.
    - Otherwise go to NEG.
  - **NEG**
    - Drive `alu_opc`=000, `alu_a`=B.
    - NB←`alu_w`; go to SUB.
  - **SUB**
    - Drive `alu_opc`=010, `alu_a`=A, `alu_b`=NB, `alu_c`=0.
    - If `alu_zer`=1 (A=B): `gcd`←A; go to DONE.
    - Else if `alu_neg`=1 (A<B): swap A↔B; go to NEG.
    - Else: A←`alu_w`; stay in SUB. NB remains valid.
  - **DONE**
    - `done`=1, `alu_opc`=111; go to IDLE.
- Arithmetic rules:
  - All operands are ≤ 32767, so A−B never overflows.
  - `alu_neg` is a true less-than.
- `start` outside IDLE is ignored, with no queuing.
- `alu_c` is tied 0 in every state.

## Timing

- Reset values: state=IDLE, A=B=NB=0, `gcd`=0, `err`=0, `done`=0, `ready`=1, `alu_opc`=111, `alu_a`=`alu_b`=0.
- `rst` low in any state returns to IDLE at that edge. An in-flight computation is discarded, and `done` does not fire for it.
- Start is accepted at edge E0.
- Latency in edges to DONE entry = 1 (NEG) + number of SUB cycles + 1 NEG per swap. `done` is high during the following cycle.
- Error path: DONE is entered at E0 and `done` is high during the cycle after E0.
- `gcd` and `err` update on the DONE-entry edge and are stable while `done`=1.
- `start` held high continuously: a new operation is accepted in the first IDLE cycle after DONE, so the back-to-back turnaround is 1 idle cycle.
- Worst-case latency (e.g. 1, 32767) is about 32770 cycles. There is no watchdog.

## Test plan

- Reset: assert `rst`=0 for 2 cycles mid-computation of (12,8). Required: `ready`=1, `gcd`=0, `err`=0, `alu_opc`=111, and no `done` pulse.
- (12,8): NEG, SUB→4, swap, NEG, SUB→4, SUB zer. Required: `done` pulse in the cycle after edge E6, `gcd`=4, `err`=0. `alu_opc` sequence: 000, 010, 010, 000, 010, 010.
- (5,5): required: DONE entry at E2, `gcd`=5.
- (7,1): required: six SUB updates (A = 6, 5, 4, 3, 2, 1), then zer at E8, `gcd`=1.
- Invalid operands (0,9) and (16'h8000,3): required: `done` in the cycle after E0, `err`=1, `gcd`=0. A following valid (9,6) clears `err` and gives `gcd`=3.
- Busy: pulse `start` with (4,2) while (12,8) is running. Required: ignored, result stays 4, exactly one `done` pulse.
